// File: rtl/memory_access_sequencer_pkg.sv
// Shared types and helpers for the memory access sequencer: channel FSM
// state encoding, region select values and the wait-counter width rule.
package memory_access_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } chan_state_e;

    localparam logic REGION_MEMORY  = 1'b0;
    localparam logic REGION_STORAGE = 1'b1;

    // One spare bit over clog2 keeps a latency of 1 at a nonzero counter width.
    function automatic int lat_cnt_width(input int max_latency);
        return $clog2(max_latency) + 1;
    endfunction

endpackage

// File: rtl/memory_access_sequencer_channel_fsm.sv
// Request/busy/done handshake with a per-target wait counter. The select input
// picks LATENCY_A (sel=0) or LATENCY_B (sel=1) at accept and is held for the access.
module access_channel_fsm
    import memory_access_sequencer_pkg::*;
#(
    parameter int LATENCY_A = 1,
    parameter int LATENCY_B = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic request,
    input  logic sel,
    output logic busy,
    output logic accept,
    output logic capture,
    output logic done,
    output logic sel_latched
);

    localparam int MAX_LATENCY = (LATENCY_A > LATENCY_B) ? LATENCY_A : LATENCY_B;
    localparam int CW = lat_cnt_width(MAX_LATENCY);
    localparam logic [CW-1:0] LOAD_A = CW'(LATENCY_A - 1);
    localparam logic [CW-1:0] LOAD_B = CW'(LATENCY_B - 1);

    chan_state_e   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          sel_q, sel_d;
    logic          done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (request) begin
                    state_d = ST_WAIT;
                    sel_d   = sel;
                    count_d = sel ? LOAD_B : LOAD_A;
                end
            end
            ST_WAIT: begin
                if (count_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The done pulse is registered off the DONE state so it appears once busy has dropped.
    always_comb begin
        busy    = (state_q != ST_IDLE);
        accept  = (state_q == ST_IDLE) && request;
        capture = (state_q == ST_WAIT) && (count_q == '0);
        done_d  = (state_q == ST_DONE);
    end

    assign done        = done_q;
    assign sel_latched = sel_q;

endmodule

// File: rtl/memory_access_sequencer.sv
// Two independent access channels (instruction fetch, data load/store) that
// register array addresses at accept and stall the core for per-region wait states.
module memory_access_sequencer
    import memory_access_sequencer_pkg::*;
#(
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    ADDR_WIDTH        = 14,
    parameter int                    INSTRUCTION_SIZE  = 16,
    parameter int                    BIOS_ADDRESS_SIZE = 9,
    parameter logic [DATA_WIDTH-1:0] STORAGE_BASE      = 32'h0000_4000,
    parameter int                    MEMORY_LATENCY    = 1,
    parameter int                    STORAGE_LATENCY   = 4,
    parameter int                    BIOS_LATENCY      = 1
) (
    input  logic                         fast_clock,
    input  logic                         reset,
    input  logic                         is_bios,
    input  logic                         instruction_request,
    input  logic [DATA_WIDTH-1:0]        original_instruction_address,
    output logic                         instruction_busy,
    output logic                         instruction_done,
    output logic [INSTRUCTION_SIZE-1:0]  output_instruction,
    input  logic                         data_request,
    input  logic                         data_write,
    input  logic [DATA_WIDTH-1:0]        original_address,
    input  logic [DATA_WIDTH-1:0]        MemOut,
    output logic                         data_busy,
    output logic                         data_done,
    output logic [DATA_WIDTH-1:0]        data_read_from_memory,
    output logic [ADDR_WIDTH-1:0]        memory_address,
    output logic [ADDR_WIDTH-1:0]        storage_address,
    output logic [ADDR_WIDTH-1:0]        instruction_address,
    output logic [BIOS_ADDRESS_SIZE:0]   bios_address,
    output logic                         memory_write_enable,
    output logic                         storage_write_enable,
    output logic [DATA_WIDTH-1:0]        write_data,
    input  logic [DATA_WIDTH-1:0]        memory_data,
    input  logic [DATA_WIDTH-1:0]        storage_data,
    input  logic [INSTRUCTION_SIZE-1:0]  memory_instruction,
    input  logic [INSTRUCTION_SIZE-1:0]  bios_instruction
);

    logic                  is_storage;
    logic [DATA_WIDTH-1:0] storage_offset;
    logic                  data_accept, data_capture, data_region;
    logic                  instr_accept, instr_capture, instr_from_bios;
    logic                  unused_bits;

    logic [ADDR_WIDTH-1:0]        memory_address_q, memory_address_d;
    logic [ADDR_WIDTH-1:0]        storage_address_q, storage_address_d;
    logic [DATA_WIDTH-1:0]        write_data_q, write_data_d;
    logic                         memory_we_q, memory_we_d;
    logic                         storage_we_q, storage_we_d;
    logic                         data_write_q, data_write_d;
    logic [DATA_WIDTH-1:0]        data_read_q, data_read_d;
    logic [ADDR_WIDTH-1:0]        instruction_address_q, instruction_address_d;
    logic [BIOS_ADDRESS_SIZE:0]   bios_address_q, bios_address_d;
    logic [INSTRUCTION_SIZE-1:0]  output_instruction_q, output_instruction_d;

    assign is_storage     = (original_address >= STORAGE_BASE) ? REGION_STORAGE : REGION_MEMORY;
    assign storage_offset = original_address - STORAGE_BASE;
    assign unused_bits    = ^{original_instruction_address[DATA_WIDTH-1:ADDR_WIDTH],
                              storage_offset[DATA_WIDTH-1:ADDR_WIDTH]};

    access_channel_fsm #(
        .LATENCY_A (MEMORY_LATENCY),
        .LATENCY_B (STORAGE_LATENCY)
    ) u_data_fsm (
        .clk         (fast_clock),
        .reset       (reset),
        .request     (data_request),
        .sel         (is_storage),
        .busy        (data_busy),
        .accept      (data_accept),
        .capture     (data_capture),
        .done        (data_done),
        .sel_latched (data_region)
    );

    access_channel_fsm #(
        .LATENCY_A (MEMORY_LATENCY),
        .LATENCY_B (BIOS_LATENCY)
    ) u_instr_fsm (
        .clk         (fast_clock),
        .reset       (reset),
        .request     (instruction_request),
        .sel         (is_bios),
        .busy        (instruction_busy),
        .accept      (instr_accept),
        .capture     (instr_capture),
        .done        (instruction_done),
        .sel_latched (instr_from_bios)
    );

    always_ff @(posedge fast_clock) begin
        if (reset) begin
            memory_address_q      <= '0;
            storage_address_q     <= '0;
            write_data_q          <= '0;
            memory_we_q           <= 1'b0;
            storage_we_q          <= 1'b0;
            data_write_q          <= 1'b0;
            data_read_q           <= '0;
            instruction_address_q <= '0;
            bios_address_q        <= '0;
            output_instruction_q  <= '0;
        end else begin
            memory_address_q      <= memory_address_d;
            storage_address_q     <= storage_address_d;
            write_data_q          <= write_data_d;
            memory_we_q           <= memory_we_d;
            storage_we_q          <= storage_we_d;
            data_write_q          <= data_write_d;
            data_read_q           <= data_read_d;
            instruction_address_q <= instruction_address_d;
            bios_address_q        <= bios_address_d;
            output_instruction_q  <= output_instruction_d;
        end
    end

    // Write strobes are set only on the accept edge, so they cover exactly the first WAIT cycle.
    always_comb begin
        memory_address_d  = memory_address_q;
        storage_address_d = storage_address_q;
        write_data_d      = write_data_q;
        data_write_d      = data_write_q;
        data_read_d       = data_read_q;
        memory_we_d       = 1'b0;
        storage_we_d      = 1'b0;
        if (data_accept) begin
            memory_address_d  = original_address[ADDR_WIDTH-1:0];
            storage_address_d = storage_offset[ADDR_WIDTH-1:0];
            write_data_d      = MemOut;
            data_write_d      = data_write;
            memory_we_d       = data_write && (is_storage == REGION_MEMORY);
            storage_we_d      = data_write && (is_storage == REGION_STORAGE);
        end
        if (data_capture && !data_write_q) begin
            data_read_d = (data_region == REGION_STORAGE) ? storage_data : memory_data;
        end
    end

    always_comb begin
        instruction_address_d = instruction_address_q;
        bios_address_d        = bios_address_q;
        output_instruction_d  = output_instruction_q;
        if (instr_accept) begin
            instruction_address_d = original_instruction_address[ADDR_WIDTH-1:0];
            bios_address_d        = original_instruction_address[BIOS_ADDRESS_SIZE:0];
        end
        if (instr_capture) begin
            output_instruction_d = instr_from_bios ? bios_instruction : memory_instruction;
        end
    end

    assign memory_address        = memory_address_q;
    assign storage_address       = storage_address_q;
    assign write_data            = write_data_q;
    assign memory_write_enable   = memory_we_q;
    assign storage_write_enable  = storage_we_q;
    assign data_read_from_memory = data_read_q;
    assign instruction_address   = instruction_address_q;
    assign bios_address          = bios_address_q;
    assign output_instruction    = output_instruction_q;

endmodule
